// File: rtl/output_queues_pkg.sv
// Shared constants for the output queue slice: tuser field offsets,
// controller state encodings and a ceiling-log2 helper.
package output_queues_pkg;

  // tuser field offsets
  localparam int unsigned DST_PORT_POS = 24;
  localparam int unsigned SRC_PORT_POS = 16;
  localparam int unsigned LEN_POS      = 0;

  // Write controller state encodings
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WR_PKT = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

  // Ceiling log2, minimum result 1
  function automatic int unsigned log2(input int unsigned value);
    int unsigned res;
    res = 1;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// First-word fall-through FIFO: a RAM-backed queue feeding a one-entry
// output register, so a written word is visible on dout one cycle after
// the write and words stream out at one per cycle.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH               = 72,
  parameter int unsigned MAX_DEPTH_BITS      = 3,
  parameter int unsigned PROG_FULL_THRESHOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             prog_full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   depth_q, depth_d;
  logic [WIDTH-1:0]          dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      mem_rd;
  logic                      pop;
  logic [MAX_DEPTH_BITS+1:0] occupancy;

  // Refill the output register whenever it is empty or being popped
  always_comb begin
    pop          = rd_en & dout_valid_q;
    mem_rd       = (depth_q != '0) && (!dout_valid_q || pop);
    wr_ptr_d     = wr_ptr_q + MAX_DEPTH_BITS'(wr_en);
    rd_ptr_d     = rd_ptr_q + MAX_DEPTH_BITS'(mem_rd);
    depth_d      = depth_q + (MAX_DEPTH_BITS+1)'(wr_en) - (MAX_DEPTH_BITS+1)'(mem_rd);
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (mem_rd) begin
      dout_d       = mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
    end else if (pop) begin
      dout_valid_d = 1'b0;
    end
  end

  // Storage array, written without reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer, occupancy and output register state
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      depth_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      depth_q      <= depth_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Occupancy includes the word parked in the output register
  assign occupancy = (MAX_DEPTH_BITS+2)'(depth_q) + (MAX_DEPTH_BITS+2)'(dout_valid_q);
  assign prog_full = occupancy > (MAX_DEPTH_BITS+2)'(PROG_FULL_THRESHOLD);
  assign empty     = ~dout_valid_q;
  assign dout      = dout_q;

endmodule

// File: rtl/output_queues.sv
// Fans the arbiter's packet stream out to per-port FIFOs selected by the
// one-hot destination field of the first word; packets with no writable
// destination are discarded whole.
module output_queues #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_QUEUES           = 5,
  parameter int unsigned DST_PORT_POS         = output_queues_pkg::DST_PORT_POS,
  parameter int unsigned OQ_DEPTH_BITS        = 7,
  parameter int unsigned MAX_PKT_WORDS        = 63
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_0,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_0,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_0,
  output logic                                 m_axis_tvalid_0,
  output logic                                 m_axis_tlast_0,
  input  logic                                 m_axis_tready_0,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_1,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_1,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_1,
  output logic                                 m_axis_tvalid_1,
  output logic                                 m_axis_tlast_1,
  input  logic                                 m_axis_tready_1,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_2,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_2,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_2,
  output logic                                 m_axis_tvalid_2,
  output logic                                 m_axis_tlast_2,
  input  logic                                 m_axis_tready_2,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_3,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_3,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_3,
  output logic                                 m_axis_tvalid_3,
  output logic                                 m_axis_tlast_3,
  input  logic                                 m_axis_tready_3,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_4,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_4,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_4,
  output logic                                 m_axis_tvalid_4,
  output logic                                 m_axis_tlast_4,
  input  logic                                 m_axis_tready_4,

  output logic [NUM_QUEUES-1:0]                pkt_stored,
  output logic [NUM_QUEUES-1:0]                pkt_dropped,
  output logic [NUM_QUEUES-1:0]                pkt_removed
);

  import output_queues_pkg::*;

  localparam int unsigned DW     = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned UW     = C_M_AXIS_TUSER_WIDTH;
  localparam int unsigned SW     = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned FIFO_W = DW + UW + SW + 1;
  localparam int unsigned PF_THR = (1 << OQ_DEPTH_BITS) - MAX_PKT_WORDS;

  logic [1:0]            state_q, state_d;
  logic [NUM_QUEUES-1:0] wr_mask_q, wr_mask_d;
  logic [NUM_QUEUES-1:0] stored_q, stored_d;
  logic [NUM_QUEUES-1:0] dropped_q, dropped_d;
  logic [NUM_QUEUES-1:0] removed_q, removed_d;
  logic [NUM_QUEUES-1:0] dst, accept, wr_en;
  logic [NUM_QUEUES-1:0] nearly_full, empty, rd_en, tready_vec, tlast_vec;
  logic [FIFO_W-1:0]     fifo_din;
  logic [FIFO_W-1:0]     fifo_dout [NUM_QUEUES];

  assign dst      = s_axis_tuser[DST_PORT_POS +: NUM_QUEUES];
  assign fifo_din = {s_axis_tlast, s_axis_tstrb[C_S_AXIS_DATA_WIDTH/8-1:0],
                     s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:0],
                     s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:0]};

  // Input is always accepted outside reset; overload is handled by dropping
  assign s_axis_tready = ~axi_reset;

  // Packet write controller: decode first word, then hold the mask to tlast
  always_comb begin
    state_d   = state_q;
    wr_mask_d = wr_mask_q;
    wr_en     = '0;
    accept    = '0;
    dropped_d = '0;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          accept    = dst & ~nearly_full;
          wr_mask_d = accept;
          wr_en     = accept;
          dropped_d = dst & nearly_full;
          if (!s_axis_tlast) begin
            state_d = (accept != '0) ? WR_PKT : DROP;
          end
        end
      end
      WR_PKT: begin
        if (s_axis_tvalid) begin
          wr_en = wr_mask_q;
          if (s_axis_tlast) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    stored_d  = wr_en & {NUM_QUEUES{s_axis_tlast}};
    removed_d = rd_en & tlast_vec;
  end

  // Controller state and registered event pulses
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q   <= IDLE;
      wr_mask_q <= '0;
      stored_q  <= '0;
      dropped_q <= '0;
      removed_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_mask_q <= wr_mask_d;
      stored_q  <= stored_d;
      dropped_q <= dropped_d;
      removed_q <= removed_d;
    end
  end

  assign pkt_stored  = stored_q;
  assign pkt_dropped = dropped_q;
  assign pkt_removed = removed_q;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_queue
    fallthrough_small_fifo #(
      .WIDTH               (FIFO_W),
      .MAX_DEPTH_BITS      (OQ_DEPTH_BITS),
      .PROG_FULL_THRESHOLD (PF_THR)
    ) u_fifo (
      .clk       (axi_aclk),
      .reset     (axi_reset),
      .din       (fifo_din),
      .wr_en     (wr_en[i]),
      .rd_en     (rd_en[i]),
      .dout      (fifo_dout[i]),
      .prog_full (nearly_full[i]),
      .empty     (empty[i])
    );
    assign tlast_vec[i] = fifo_dout[i][FIFO_W-1];
  end

  assign tready_vec = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2,
                       m_axis_tready_1, m_axis_tready_0};
  assign rd_en      = tready_vec & ~empty;

  assign m_axis_tdata_0  = fifo_dout[0][DW-1:0];
  assign m_axis_tuser_0  = fifo_dout[0][DW+UW-1:DW];
  assign m_axis_tstrb_0  = fifo_dout[0][DW+UW+SW-1:DW+UW];
  assign m_axis_tlast_0  = fifo_dout[0][FIFO_W-1];
  assign m_axis_tvalid_0 = ~empty[0];

  assign m_axis_tdata_1  = fifo_dout[1][DW-1:0];
  assign m_axis_tuser_1  = fifo_dout[1][DW+UW-1:DW];
  assign m_axis_tstrb_1  = fifo_dout[1][DW+UW+SW-1:DW+UW];
  assign m_axis_tlast_1  = fifo_dout[1][FIFO_W-1];
  assign m_axis_tvalid_1 = ~empty[1];

  assign m_axis_tdata_2  = fifo_dout[2][DW-1:0];
  assign m_axis_tuser_2  = fifo_dout[2][DW+UW-1:DW];
  assign m_axis_tstrb_2  = fifo_dout[2][DW+UW+SW-1:DW+UW];
  assign m_axis_tlast_2  = fifo_dout[2][FIFO_W-1];
  assign m_axis_tvalid_2 = ~empty[2];

  assign m_axis_tdata_3  = fifo_dout[3][DW-1:0];
  assign m_axis_tuser_3  = fifo_dout[3][DW+UW-1:DW];
  assign m_axis_tstrb_3  = fifo_dout[3][DW+UW+SW-1:DW+UW];
  assign m_axis_tlast_3  = fifo_dout[3][FIFO_W-1];
  assign m_axis_tvalid_3 = ~empty[3];

  assign m_axis_tdata_4  = fifo_dout[4][DW-1:0];
  assign m_axis_tuser_4  = fifo_dout[4][DW+UW-1:DW];
  assign m_axis_tstrb_4  = fifo_dout[4][DW+UW+SW-1:DW+UW];
  assign m_axis_tlast_4  = fifo_dout[4][FIFO_W-1];
  assign m_axis_tvalid_4 = ~empty[4];

endmodule

// File: tb/tb_output_queues.sv
// Scoreboard bench for output_queues: stimulus pushes expected words per
// queue, a negedge monitor pops and compares every word handed out.
module tb_output_queues;

  typedef struct packed {
    logic         last;
    logic [31:0]  strb;
    logic [127:0] user;
    logic [255:0] data;
  } word_t;

  logic         clk;
  logic         rst;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [255:0] m_tdata [5];
  logic [31:0]  m_tstrb [5];
  logic [127:0] m_tuser [5];
  logic [4:0]   m_tvalid;
  logic [4:0]   m_tlast;
  logic [4:0]   m_tready;
  logic [4:0]   pkt_stored, pkt_dropped, pkt_removed;

  word_t exp_q [5][$];
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_st [5];
  int    exp_dr [5];
  int    exp_rm [5];
  int    act_st [5];
  int    act_dr [5];
  int    act_rm [5];

  output_queues #(
    .C_M_AXIS_DATA_WIDTH  (256),
    .C_S_AXIS_DATA_WIDTH  (256),
    .C_M_AXIS_TUSER_WIDTH (128),
    .C_S_AXIS_TUSER_WIDTH (128),
    .NUM_QUEUES           (5),
    .DST_PORT_POS         (24),
    .OQ_DEPTH_BITS        (7),
    .MAX_PKT_WORDS        (63)
  ) dut (
    .axi_aclk        (clk),
    .axi_reset       (rst),
    .s_axis_tdata    (s_tdata),
    .s_axis_tstrb    (s_tstrb),
    .s_axis_tuser    (s_tuser),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_tready),
    .m_axis_tdata_0  (m_tdata[0]), .m_axis_tstrb_0 (m_tstrb[0]), .m_axis_tuser_0 (m_tuser[0]),
    .m_axis_tvalid_0 (m_tvalid[0]), .m_axis_tlast_0 (m_tlast[0]), .m_axis_tready_0 (m_tready[0]),
    .m_axis_tdata_1  (m_tdata[1]), .m_axis_tstrb_1 (m_tstrb[1]), .m_axis_tuser_1 (m_tuser[1]),
    .m_axis_tvalid_1 (m_tvalid[1]), .m_axis_tlast_1 (m_tlast[1]), .m_axis_tready_1 (m_tready[1]),
    .m_axis_tdata_2  (m_tdata[2]), .m_axis_tstrb_2 (m_tstrb[2]), .m_axis_tuser_2 (m_tuser[2]),
    .m_axis_tvalid_2 (m_tvalid[2]), .m_axis_tlast_2 (m_tlast[2]), .m_axis_tready_2 (m_tready[2]),
    .m_axis_tdata_3  (m_tdata[3]), .m_axis_tstrb_3 (m_tstrb[3]), .m_axis_tuser_3 (m_tuser[3]),
    .m_axis_tvalid_3 (m_tvalid[3]), .m_axis_tlast_3 (m_tlast[3]), .m_axis_tready_3 (m_tready[3]),
    .m_axis_tdata_4  (m_tdata[4]), .m_axis_tstrb_4 (m_tstrb[4]), .m_axis_tuser_4 (m_tuser[4]),
    .m_axis_tvalid_4 (m_tvalid[4]), .m_axis_tlast_4 (m_tlast[4]), .m_axis_tready_4 (m_tready[4]),
    .pkt_stored      (pkt_stored),
    .pkt_dropped     (pkt_dropped),
    .pkt_removed     (pkt_removed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 5; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Present one word and push it onto the scoreboard of every queue in mask
  task automatic drive_word(input int id, input int w, input logic [4:0] dst,
                            input bit last, input logic [4:0] mask);
    logic [15:0] idv;
    logic [15:0] wv;
    word_t       e;
    idv      = id[15:0];
    wv       = w[15:0];
    s_tdata  = {8{idv, wv}};
    s_tuser  = (128'(dst) << 24) | 128'(idv);
    s_tstrb  = last ? 32'h0000_ffff : 32'hffff_ffff;
    s_tlast  = last;
    s_tvalid = 1'b1;
    e        = '{last: last, strb: s_tstrb, user: s_tuser, data: s_tdata};
    for (int i = 0; i < 5; i++) if (mask[i]) exp_q[i].push_back(e);
  endtask

  // Send a packet back to back; mask/drop are the hand-derived outcomes
  task automatic send_pkt(input int id, input logic [4:0] dst, input int n,
                          input logic [4:0] mask, input logic [4:0] drop, input bit lat);
    for (int w = 0; w < n; w++) begin
      drive_word(id, w, dst, (w == n - 1), mask);
      @(posedge clk); #1;
      if (w == 0) begin
        chk($sformatf("dropped_p%0d", id), 64'(pkt_dropped), 64'(drop));
        if (lat) chk($sformatf("lat_t1_p%0d", id), 64'(m_tvalid & mask), 64'd0);
      end
      if (w == 1 && lat) chk($sformatf("lat_t2_p%0d", id), 64'(m_tvalid & mask), 64'(mask));
      if (w == n - 1) chk($sformatf("stored_p%0d", id), 64'(pkt_stored), 64'(mask));
    end
    for (int i = 0; i < 5; i++) begin
      exp_st[i] += int'(mask[i]);
      exp_rm[i] += int'(mask[i]);
      exp_dr[i] += int'(drop[i]);
    end
  endtask

  task automatic drain();
    int k = 0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    while ((pending() != 0 || m_tvalid != 5'd0) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (k >= 3000) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d words left expected 0", pending());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every handshake, count event pulses
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        if (pkt_stored[i])  act_st[i]++;
        if (pkt_dropped[i]) act_dr[i]++;
        if (pkt_removed[i]) act_rm[i]++;
        if (m_tvalid[i] && m_tready[i]) begin
          word_t got;
          word_t e;
          got = '{last: m_tlast[i], strb: m_tstrb[i], user: m_tuser[i], data: m_tdata[i]};
          n_vec++;
          if (exp_q[i].size() == 0) begin
            n_err++;
            $display("FAIL q%0d_unexpected: got %0h expected no word", i, got);
          end else begin
            e = exp_q[i].pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL q%0d_word: got %0h expected %0h", i, got, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      exp_st[i] = 0; exp_dr[i] = 0; exp_rm[i] = 0;
      act_st[i] = 0; act_dr[i] = 0; act_rm[i] = 0;
    end
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tstrb  = '0;
    m_tready = 5'b11111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_pulses", 64'({pkt_stored, pkt_dropped, pkt_removed}), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    rst = 1'b0;
    #1;
    chk("run_tready", 64'(s_tready), 64'd1);

    // Unicast to queue 2 with latency check
    send_pkt(1, 5'b00100, 4, 5'b00100, 5'b00000, 1'b1);
    drain();

    // Multicast to queues 0, 1, 4
    send_pkt(2, 5'b10011, 3, 5'b10011, 5'b00000, 1'b1);
    drain();

    // Fill queue 1 while it is stalled: 63 + 63 words pushes it past the threshold
    m_tready = 5'b11101;
    send_pkt(3, 5'b00010, 63, 5'b00010, 5'b00000, 1'b0);
    send_pkt(4, 5'b00010, 63, 5'b00010, 5'b00000, 1'b0);
    send_pkt(5, 5'b00011, 3,  5'b00001, 5'b00010, 1'b0);
    send_pkt(6, 5'b00010, 2,  5'b00000, 5'b00010, 1'b0);
    chk("drop_tready", 64'(s_tready), 64'd1);
    s_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    m_tready = 5'b11111;
    drain();

    // Single-word packet immediately followed by a two-word packet
    send_pkt(7, 5'b00001, 1, 5'b00001, 5'b00000, 1'b0);
    send_pkt(8, 5'b01000, 2, 5'b01000, 5'b00000, 1'b0);
    drain();

    // No destination, then a normally routed packet
    send_pkt(9,  5'b00000, 5, 5'b00000, 5'b00000, 1'b0);
    send_pkt(10, 5'b10000, 2, 5'b10000, 5'b00000, 1'b0);
    drain();

    // Reset on word 3 of 8; stale words must never appear
    m_tready = 5'b11110;
    for (int w = 0; w < 3; w++) begin
      drive_word(11, w, 5'b00001, 1'b0, 5'b00000);
      @(posedge clk); #1;
    end
    drive_word(11, 3, 5'b00001, 1'b0, 5'b00000);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_tready", 64'(s_tready), 64'd0);
    rst      = 1'b0;
    m_tready = 5'b11111;
    send_pkt(12, 5'b00100, 4, 5'b00100, 5'b00000, 1'b1);
    drain();

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stored_cnt_q%0d", i),  64'(act_st[i]), 64'(exp_st[i]));
      chk($sformatf("dropped_cnt_q%0d", i), 64'(act_dr[i]), 64'(exp_dr[i]));
      chk($sformatf("removed_cnt_q%0d", i), 64'(act_rm[i]), 64'(exp_rm[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_queues.md
# output_queues

Splits the single packet stream produced by the input arbiter into NUM_QUEUES per-port output streams. It decodes the one-hot destination field in the first-word tuser and writes every word of the packet into each selected, non-full per-port FIFO. Packets with no writable destination are dropped whole. It sits directly downstream of the arbiter/lookup path and feeds the MAC TX and DMA interfaces.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, output tdata width (tstrb = width/8)
- C_S_AXIS_DATA_WIDTH, 256, input tdata width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width; must equal C_M_AXIS_TUSER_WIDTH
- NUM_QUEUES, 5, number of output ports
- DST_PORT_POS, 24, LSB of the destination field; queue i is selected by tuser[DST_PORT_POS+i]
- OQ_DEPTH_BITS, 7, per-queue FIFO depth is 2^OQ_DEPTH_BITS words
- MAX_PKT_WORDS, 63, words in a 2000-byte packet at 32 B/word

Ports:
- axi_aclk  in  1  clock
- axi_reset  in  1  synchronous, active-high reset
- s_axis_tdata / tstrb / tuser / tvalid / tlast  in  widths per parameters  input stream
- s_axis_tready  out  1  input ready
- m_axis_tdata_i / tstrb_i / tuser_i / tvalid_i / tlast_i  out  widths per parameters  output stream for queue i, i = 0..4
- m_axis_tready_i  in  1  ready for queue i, i = 0..4
- pkt_stored  out  NUM_QUEUES  one-cycle pulse per queue when a packet's last word is written
- pkt_dropped  out  NUM_QUEUES  one-cycle pulse per queue when a selected queue refuses a packet
- pkt_removed  out  NUM_QUEUES  one-cycle pulse per queue when the last word leaves on m_axis

## Operation
- FSM states: IDLE, WR_PKT, DROP. Reset state is IDLE.
- IDLE, s_axis_tvalid=1 (this is the first word):
  - dst = tuser[DST_PORT_POS +: NUM_QUEUES]
  - accept = dst & ~nearly_full
  - Latch accept into wr_mask and write the word into every queue in accept.
  - pkt_dropped is set to dst & nearly_full on this cycle.
- Transitions out of IDLE on the first word:
  - accept≠0 and tlast=0 → WR_PKT
  - accept=0 and tlast=0 → DROP
  - tlast=1 → stay IDLE
- WR_PKT: each valid word is written to the queues in wr_mask. On tlast → IDLE.
- DROP: each valid word is consumed and discarded. On tlast → IDLE.
- dst=0: the packet is dropped with no pulses.
- wr_mask is fixed for the whole packet. A queue crossing nearly_full mid-packet keeps receiving that packet.
- nearly_full[i] = free words < MAX_PKT_WORDS. A full packet therefore always fits, and a FIFO never overflows.
- s_axis_tready is 1 in every state except during reset. Backpressure is never applied; overload is handled by dropping.
- tdata, tstrb, tuser and tlast pass through unmodified.
- Output ports are independent. A stalled m_axis_tready_i never blocks the other queues.
- Counter pulses:
  - pkt_stored[i] fires on the write cycle of a tlast word to queue i.
  - pkt_removed[i] fires when m_axis_tvalid_i & m_axis_tready_i & m_axis_tlast_i.
  - A stored pulse and a removed pulse on the same queue in the same cycle are both asserted.
- Reset mid-packet clears all FIFOs and returns the FSM to IDLE. The next valid input word is treated as a first word.

## Timing
- Reset values: every m_axis_tvalid_i=0, pkt_stored=0, pkt_dropped=0, pkt_removed=0. s_axis_tready=0 while axi_reset=1.
- Write path: a word accepted at edge t appears on m_axis_*_i with tvalid_i=1 from cycle t+2 (fall-through FIFO).
- Read path:
  - m_axis_tvalid_i = ~empty[i]
  - A word is popped on the edge where tvalid_i & tready_i.
  - Back-to-back words stream at one per cycle.
- pkt_dropped is combinational from the first-word cycle, registered, and asserted at t+1. pkt_stored and pkt_removed are also registered (cycle after the event).
- Simultaneous write and read on one FIFO in the same cycle is legal; occupancy is unchanged.

## Structure
- Shared package/header holds:
  - the tuser field offsets (DST_PORT_POS, SRC_PORT_POS=16, LEN_POS=0)
  - the FSM state encodings
  - the log2 function
- One sub-module: fallthrough_small_fifo, one instance per queue.
  - WIDTH = data + tuser + strb + 1
  - MAX_DEPTH_BITS = OQ_DEPTH_BITS
  - prog_full threshold = 2^OQ_DEPTH_BITS − MAX_PKT_WORDS, driving nearly_full
- Output port flattening is written out explicitly per queue (_0.._4).

## Test plan
- Unicast: 4-word packet with dst=5'b00100, all outputs ready → appears only on queue 2, 4 words, tvalid_2 from cycle t+2; pkt_stored=5'b00100 once, then pkt_removed=5'b00100.
- Multicast: dst=5'b10011, 3 words → identical 3-word copies on queues 0, 1 and 4; queues 2 and 3 stay idle.
- Full queue:
  - Stimulus: m_axis_tready_1=0, then 63-word packets to queue 1 until nearly_full.
  - The next packet with dst=5'b00011 goes to queue 0 only; pkt_dropped=5'b00010.
  - A later packet with dst=5'b00010 → DROP state, nothing written, s_axis_tready stays 1.
- Single-word packet (tlast on the first word) followed immediately by a 2-word packet to a different queue → both delivered, FSM never enters WR_PKT for the first packet.
- dst=0 packet of 5 words → discarded, no pulses; the next packet is routed normally.
- Reset asserted mid-packet (word 3 of 8) → all tvalid_i=0 the next cycle; after release, the next word is decoded as a header.
